// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and fills the
// IF/ID pipeline register, honouring reset > redirect > stall > sequential fetch.
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'hBFC00000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  pc_sel,
    input  logic [DATA_WIDTH-1:0] branch_target,
    output logic [DATA_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0] instr_in,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] pc_plus4_d,
    output logic                  valid_d,
    output logic                  misaligned,
    output logic [31:0]           redirect_count
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);
    localparam logic [31:0]           CNT_MAX = 32'hFFFFFFFF;

    logic [DATA_WIDTH-1:0] pc_q,         pc_d_s;
    logic [DATA_WIDTH-1:0] if_instr_q,   if_instr_d;
    logic [DATA_WIDTH-1:0] if_pc_q,      if_pc_d;
    logic [DATA_WIDTH-1:0] if_pc4_q,     if_pc4_d;
    logic                  if_valid_q,   if_valid_d;
    logic                  misalign_q,   misalign_d;
    logic [31:0]           redir_cnt_q,  redir_cnt_d;
    logic [DATA_WIDTH-1:0] pc_plus4_s;

    assign pc_plus4_s = pc_q + PC_STEP;

    // Next-state selection for the PC, IF/ID register and redirect bookkeeping.
    always_comb begin
        pc_d_s      = pc_q;
        if_instr_d  = if_instr_q;
        if_pc_d     = if_pc_q;
        if_pc4_d    = if_pc4_q;
        if_valid_d  = if_valid_q;
        misalign_d  = 1'b0;
        redir_cnt_d = redir_cnt_q;

        if (pc_sel) begin
            // Flush wins over stall so a redirect is never dropped; pc_d/pc_plus4_d hold.
            pc_d_s      = {branch_target[DATA_WIDTH-1:1], 1'b0};
            if_instr_d  = NOP_INSTR;
            if_valid_d  = 1'b0;
            misalign_d  = branch_target[1];
            redir_cnt_d = (redir_cnt_q == CNT_MAX) ? redir_cnt_q : redir_cnt_q + 32'd1;
        end else if (stall) begin
            pc_d_s = pc_q;
        end else begin
            pc_d_s     = pc_plus4_s;
            if_instr_d = instr_in;
            if_pc_d    = pc_q;
            if_pc4_d   = pc_plus4_s;
            if_valid_d = 1'b1;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            if_instr_q  <= NOP_INSTR;
            if_pc_q     <= '0;
            if_pc4_q    <= '0;
            if_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            redir_cnt_q <= 32'd0;
        end else begin
            pc_q        <= pc_d_s;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
            if_pc4_q    <= if_pc4_d;
            if_valid_q  <= if_valid_d;
            misalign_q  <= misalign_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign instr_addr     = pc_q;
    assign instr_d        = if_instr_q;
    assign pc_d           = if_pc_q;
    assign pc_plus4_d     = if_pc4_q;
    assign valid_d        = if_valid_q;
    assign misaligned     = misalign_q;
    assign redirect_count = redir_cnt_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the execute-stage branch resolver.
- Owns the program counter and drives the instruction-memory address.
- Registers fetched instruction, PC and PC+4 into the IF/ID pipeline register.
- Consumes the resolver's redirect decision (pc_sel) and target; handles stall, flush and redirect.

Parameters:
- DATA_WIDTH, 32, width of PC, instruction and target buses.
- RESET_PC, 32'hBFC00000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, instruction injected into IF/ID on flush (addi x0,x0,0).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit stall request; hold PC and IF/ID.
- pc_sel  input  1  redirect request from the branch resolver in execute (1 = take target).
- branch_target  input  DATA_WIDTH  redirect target computed in execute.
- instr_addr  output  DATA_WIDTH  instruction-memory address; equals the current PC.
- instr_in  input  DATA_WIDTH  instruction word returned combinationally for instr_addr.
- instr_d  output  DATA_WIDTH  IF/ID registered instruction.
- pc_d  output  DATA_WIDTH  IF/ID registered PC of instr_d.
- pc_plus4_d  output  DATA_WIDTH  IF/ID registered pc_d + 4.
- valid_d  output  1  IF/ID entry holds a real instruction (0 = bubble).
- misaligned  output  1  one-cycle pulse: redirect target had bit 1 set.
- redirect_count  output  32  saturating count of accepted redirects.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - PC = RESET_PC.
  - instr_d = NOP_INSTR; pc_d = 0; pc_plus4_d = 0.
  - valid_d = 0; misaligned = 0; redirect_count = 0.
  - rst has priority over every other input in the same cycle.
- instr_addr = PC, combinational from the PC register. Memory latency is zero: instr_in is valid in the same cycle.
- Next-PC priority, evaluated each rising edge:
  1. rst.
  2. pc_sel = 1: PC <= {branch_target[DATA_WIDTH-1:1], 1'b0}. Bit 0 is always cleared.
  3. stall = 1: PC holds.
  4. Otherwise: PC <= PC + 4, modulo 2^DATA_WIDTH. 32'hFFFFFFFC wraps to 0 with no flag.
- IF/ID register, same priority:
  - pc_sel = 1 (flush): instr_d <= NOP_INSTR, valid_d <= 0. pc_d and pc_plus4_d hold their previous values.
  - pc_sel = 1 overrides a simultaneous stall. The redirect is never lost.
  - stall = 1 with pc_sel = 0: all IF/ID outputs hold.
  - Otherwise: instr_d <= instr_in, pc_d <= PC, pc_plus4_d <= PC + 4, valid_d <= 1.
- Redirect latency:
  - The target is fetched in the cycle after pc_sel is sampled.
  - Its instruction appears on instr_d with valid_d = 1 two edges after pc_sel.
  - The cycle between is a bubble (valid_d = 0).
- misaligned:
  - Registered. It is 1 in the cycle after an accepted redirect whose branch_target[1] = 1; otherwise 0.
  - It never holds across cycles.
  - The PC still takes the bit-0-cleared target; trap handling is downstream.
- redirect_count:
  - Increments by 1 on each edge with pc_sel = 1 and rst = 0.
  - Saturates at 32'hFFFFFFFF; no wrap.
- Back-to-back pc_sel on consecutive cycles: each is honoured and the last one wins. valid_d stays 0 throughout.
- rst asserted mid-stall or mid-redirect discards all pending state. The first fetch after rst deasserts is RESET_PC.
- No combinational path from pc_sel or stall to any output. instr_addr depends only on the PC register.

Test Plan:
- Reset and sequential fetch: hold rst 2 cycles, then release with stall = 0, pc_sel = 0. Required: instr_addr = BFC00000, BFC00004, BFC00008 on successive cycles. valid_d is 0 in the first cycle after release, then 1, with pc_d lagging instr_addr by one cycle.
- Stall: assert stall for 3 cycles while PC = BFC00008. Required: instr_addr stays BFC00008, IF/ID outputs are frozen, valid_d is unchanged. On release, PC = BFC0000C on the next edge.
- Redirect with simultaneous stall: pc_sel = 1, stall = 1, branch_target = BFC00100. Required:
  - Next cycle: instr_addr = BFC00100, valid_d = 0, instr_d = 00000013, redirect_count += 1.
  - One cycle later: pc_d = BFC00100, valid_d = 1.
- Misaligned target: branch_target = BFC00203. Required: PC = BFC00202 and misaligned = 1 for exactly one cycle.
- Wrap and saturation:
  - Force PC to FFFFFFFC. Required: next PC = 00000000.
  - Preload redirect_count to FFFFFFFE and apply 3 redirects. Required: count ends at FFFFFFFF.
- Reset mid-redirect: rst and pc_sel both 1, target = 1000. Required: PC = BFC00000, valid_d = 0, redirect_count = 0.
